// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared state encoding, op constants and helpers for the calculator sequencer
package calc_pkg;

    typedef enum logic [2:0] {
        ST_ENTRY    = 3'd0,
        ST_GRANT    = 3'd1,
        ST_SHOW     = 3'd2,
        ST_CONFLICT = 3'd3,
        ST_ERROR    = 3'd4
    } state_t;

    localparam logic [4:0] OP_NONE = 5'b00000;

    function automatic logic onehot5(input logic [4:0] v);
        return (v != 5'b00000) && ((v & (v - 5'd1)) == 5'b00000);
    endfunction

endpackage

// File: rtl/calc_debounce.sv
// rtl/calc_debounce.sv - 2-flop synchronizer, saturating debounce counter and rising-edge pulse
module calc_debounce #(
    parameter int DEB_CYC = 1_000_000,
    parameter int DEB_W   = 20
) (
    input  logic clock,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam logic [DEB_W-1:0] CNT_MAX = DEB_W'(DEB_CYC);

    logic [1:0]       sync_q;
    logic             prev_q;
    logic [DEB_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             rise_q, rise_d;

    // Level follows the synced input in the same cycle the counter saturates,
    // giving a raw-to-level latency of 2 + DEB_CYC + 1 cycles.
    always_comb begin
        cnt_d = cnt_q;
        if (sync_q[1] != prev_q) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + DEB_W'(1);
        end
        level_d = (cnt_d == CNT_MAX) ? sync_q[1] : level_q;
        rise_d  = level_d & ~level_q;
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            sync_q  <= 2'b00;
            prev_q  <= 1'b0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], raw};
            prev_q  <= sync_q[1];
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
        end
    end

    assign level = level_q;
    assign rise  = rise_q;

endmodule

// File: rtl/calc_sequencer.sv
// rtl/calc_sequencer.sv - input conditioning and entry/grant/show/conflict/error sequencing
module calc_sequencer
    import calc_pkg::*;
#(
    parameter int DEB_CYC = 1_000_000,
    parameter int DEB_W   = 20
) (
    input  logic       clock,
    input  logic       rst,
    input  logic [3:0] btn,
    input  logic [4:0] sw,
    input  logic       dp_error,
    output logic [3:0] digit_inc,
    output logic       digit_clr,
    output logic [4:0] op_sel,
    output logic       result_valid,
    output logic       err_show,
    output logic       disp_blank,
    output logic [2:0] state_dbg
);

    logic [3:0] btn_lvl, btn_rise;
    logic [4:0] sw_lvl, sw_rise;

    for (genvar i = 0; i < 4; i++) begin : g_btn
        calc_debounce #(.DEB_CYC(DEB_CYC), .DEB_W(DEB_W)) u_deb (
            .clock(clock), .rst(rst), .raw(btn[i]), .level(btn_lvl[i]), .rise(btn_rise[i])
        );
    end

    for (genvar i = 0; i < 5; i++) begin : g_sw
        calc_debounce #(.DEB_CYC(DEB_CYC), .DEB_W(DEB_W)) u_deb (
            .clock(clock), .rst(rst), .raw(sw[i]), .level(sw_lvl[i]), .rise(sw_rise[i])
        );
    end

    logic unused_deb;
    assign unused_deb = ^{btn_lvl, sw_rise};

    state_t     state_q, state_d;
    logic [4:0] op_sel_q, op_sel_d;
    logic [3:0] digit_inc_q, digit_inc_d;
    logic       digit_clr_q, digit_clr_d;
    logic       result_valid_q, result_valid_d;
    logic       err_show_q, err_show_d;
    logic       disp_blank_q, disp_blank_d;

    always_comb begin
        state_d     = state_q;
        op_sel_d    = op_sel_q;
        digit_inc_d = 4'b0000;
        digit_clr_d = 1'b0;
        case (state_q)
            ST_ENTRY: begin
                if (sw_lvl == OP_NONE) begin
                    digit_inc_d = btn_rise;
                end else if (onehot5(sw_lvl)) begin
                    // A grant in the same cycle as a button edge drops that edge.
                    state_d  = ST_GRANT;
                    op_sel_d = sw_lvl;
                end else begin
                    state_d  = ST_CONFLICT;
                    op_sel_d = OP_NONE;
                end
            end
            ST_GRANT: begin
                state_d = dp_error ? ST_ERROR : ST_SHOW;
            end
            ST_SHOW: begin
                if (dp_error) begin
                    state_d = ST_ERROR;
                end else if (sw_lvl == OP_NONE) begin
                    state_d  = ST_ENTRY;
                    op_sel_d = OP_NONE;
                end else if (!onehot5(sw_lvl)) begin
                    state_d  = ST_CONFLICT;
                    op_sel_d = OP_NONE;
                end else if (sw_lvl != op_sel_q) begin
                    state_d  = ST_GRANT;
                    op_sel_d = sw_lvl;
                end
            end
            ST_CONFLICT: begin
                op_sel_d = OP_NONE;
                if (sw_lvl == OP_NONE) begin
                    state_d = ST_ENTRY;
                end
            end
            ST_ERROR: begin
                if (sw_lvl == OP_NONE) begin
                    state_d     = ST_ENTRY;
                    op_sel_d    = OP_NONE;
                    digit_clr_d = 1'b1;
                end
            end
            default: begin
                state_d  = ST_ENTRY;
                op_sel_d = OP_NONE;
            end
        endcase
        result_valid_d = (state_d == ST_SHOW);
        err_show_d     = (state_d == ST_ERROR);
        disp_blank_d   = (state_d == ST_CONFLICT);
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state_q        <= ST_ENTRY;
            op_sel_q       <= OP_NONE;
            digit_inc_q    <= 4'b0000;
            digit_clr_q    <= 1'b0;
            result_valid_q <= 1'b0;
            err_show_q     <= 1'b0;
            disp_blank_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            op_sel_q       <= op_sel_d;
            digit_inc_q    <= digit_inc_d;
            digit_clr_q    <= digit_clr_d;
            result_valid_q <= result_valid_d;
            err_show_q     <= err_show_d;
            disp_blank_q   <= disp_blank_d;
        end
    end

    assign digit_inc    = digit_inc_q;
    assign digit_clr    = digit_clr_q;
    assign op_sel       = op_sel_q;
    assign result_valid = result_valid_q;
    assign err_show     = err_show_q;
    assign disp_blank   = disp_blank_q;
    assign state_dbg    = state_q;

endmodule
